// File: rtl/rv_divider_if.sv
// Handshake and writeback bundle between the regfile read side, the divider and the regfile write port.
interface rv_divider_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd;
  logic            busy;
  logic            we3;
  logic [4:0]      wa3;
  logic [XLEN-1:0] wd3;

  modport master (
    output start, op, a, b, rd,
    input  busy, we3, wa3, wd3
  );

  modport slave (
    input  start, op, a, b, rd,
    output busy, we3, wa3, wd3
  );
endinterface

// File: rtl/rv_divider.sv
// Iterative restoring radix-2 RV32M DIV/DIVU/REM/REMU unit with single-cycle regfile writeback.
// Optional RV_DIV_FASTPATH_EN: zero dividend or divisor skips the iteration phase.
module rv_divider #(
  parameter int unsigned XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  rv_divider_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [XLEN-1:0] rem_q, quo_q, div_q;
  logic [4:0]      cnt_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic            sa_q, sb_q, bz_q;
  logic            busy_q, we3_q;
  logic [4:0]      wa3_q;
  logic [XLEN-1:0] wd3_q;

  logic            a_neg, b_neg, signed_op;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   part;
  logic            ge;
  logic [XLEN-1:0] rem_n, quo_n, q_res, r_res, result;
`ifdef RV_DIV_FASTPATH_EN
  logic            fast;
  logic [XLEN-1:0] fast_res;
`endif

  always_comb begin
    a_neg = ~bus.op[0] & bus.a[XLEN-1];
    b_neg = ~bus.op[0] & bus.b[XLEN-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;

    // One restoring step: shift in the next dividend bit, keep the difference if it fits.
    part  = {rem_q, quo_q[XLEN-1]};
    ge    = part >= {1'b0, div_q};
    rem_n = ge ? (part[XLEN-1:0] - div_q) : part[XLEN-1:0];
    quo_n = {quo_q[XLEN-2:0], ge};

    signed_op = ~op_q[0];
    q_res  = bz_q ? '1 : ((signed_op && (sa_q ^ sb_q)) ? -quo_n : quo_n);
    r_res  = (signed_op && sa_q) ? -rem_n : rem_n;
    result = op_q[1] ? r_res : q_res;

`ifdef RV_DIV_FASTPATH_EN
    fast     = (bus.a == '0) || (bus.b == '0);
    fast_res = (bus.b == '0) ? (bus.op[1] ? bus.a : '1) : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q   <= bus.op;
            rd_q   <= bus.rd;
            sa_q   <= bus.a[XLEN-1];
            sb_q   <= bus.b[XLEN-1];
            bz_q   <= (bus.b == '0);
            quo_q  <= a_mag;
            div_q  <= b_mag;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef RV_DIV_FASTPATH_EN
            if (fast) begin
              state_q <= StDone;
              we3_q   <= (bus.rd != '0);
              wa3_q   <= bus.rd;
              wd3_q   <= fast_res;
            end else begin
              state_q <= StCalc;
            end
`else
            state_q <= StCalc;
`endif
          end
        end
        StCalc: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + 5'd1;
          // Final iteration: register the fixed-up result so it is visible throughout DONE.
          if (cnt_q == 5'd31) begin
            state_q <= StDone;
            cnt_q   <= '0;
            we3_q   <= (rd_q != '0);
            wa3_q   <= rd_q;
            wd3_q   <= result;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          we3_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.we3  = we3_q;
  assign bus.wa3  = wa3_q;
  assign bus.wd3  = wd3_q;

endmodule

// File: tb/tb_rv_divider.sv
// Directed bench for rv_divider: arithmetic reference model checked every cycle plus literal results.
module tb_rv_divider;

`ifdef RV_DIV_FASTPATH_EN
  localparam int LatZero = 1;
`else
  localparam int LatZero = 33;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rv_divider_if #(.XLEN(32)) bus ();

  rv_divider #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'd0 || b == 32'd0) ? LatZero : 33;
  endfunction

  // Reference model: cycles remaining until idle; value 1 marks the writeback cycle.
  int          m_cnt = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (bus.start) begin
        m_cnt <= lat_of(bus.a, bus.b);
        m_res <= ref_result(bus.op, bus.a, bus.b);
        m_rd  <= bus.rd;
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clk) begin
    logic exp_we;
    exp_we = (m_cnt == 1) && (m_rd != 5'd0);
    chk("cyc_busy", {31'd0, bus.busy}, {31'd0, m_cnt != 0});
    chk("cyc_we3", {31'd0, bus.we3}, {31'd0, exp_we});
    if (exp_we) begin
      chk("cyc_wa3", {27'd0, bus.wa3}, {27'd0, m_rd});
      chk("cyc_wd3", bus.wd3, m_res);
    end
  end

  // Issue one op, optionally poke a second start at loop cycle `poke`, and time the writeback.
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                     input int poke, input string name);
    logic        got_we;
    int          lat;
    logic [31:0] data;
    got_we = 1'b0;
    lat    = 0;
    data   = '0;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.rd    = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom);
    bus.rd    = 5'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == poke) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd5;
        bus.b     = 32'd3;
        bus.rd    = 5'd13;
      end
      if (i == poke + 1) bus.start = 1'b0;
      if (bus.we3) begin
        got_we = 1'b1;
        lat    = i;
        data   = bus.wd3;
      end
      if (!bus.busy) break;
    end
    chk({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
    if (rd != 5'd0) begin
      chk({name, "_we"}, {31'd0, got_we}, 32'd1);
      chk({name, "_lat"}, lat, exp_lat);
      chk({name, "_wd3"}, data, exp);
    end else begin
      chk({name, "_nowrite"}, {31'd0, got_we}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.rd    = '0;

    chk("model_divu", ref_result(2'b01, 32'd100, 32'd7), 32'd14);
    chk("model_rem", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_ovf", ref_result(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_we3", {31'd0, bus.we3}, 32'd0);
    chk("rst_wa3", {27'd0, bus.wa3}, 32'd0);
    chk("rst_wd3", bus.wd3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(2'b01, 32'd100,        32'd7,          5'd5,  32'd14,          33,      0, "divu_100_7");
    run(2'b10, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF,   33,      0, "rem_m7_2");
    run(2'b00, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,   33,      0, "div_m7_2");
    run(2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,   33,      0, "div_ovf");
    run(2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'd0,           33,      0, "rem_ovf");
    run(2'b01, 32'd1234,       32'd0,          5'd9,  32'hFFFF_FFFF,   LatZero, 0, "divu_by0");
    run(2'b11, 32'd1234,       32'd0,          5'd9,  32'd1234,        LatZero, 0, "remu_by0");
    run(2'b00, 32'hFFFF_FFEC,  32'd0,          5'd10, 32'hFFFF_FFFF,   LatZero, 0, "div_m20_by0");
    run(2'b10, 32'hFFFF_FFEC,  32'd0,          5'd10, 32'hFFFF_FFEC,   LatZero, 0, "rem_m20_by0");
    run(2'b11, 32'hFFFF_FFFF,  32'd10,         5'd11, 32'd5,           33,      0, "remu_max_10");
    run(2'b01, 32'hFFFF_FFFF,  32'd10,         5'd11, 32'h1999_9999,   33,      0, "divu_max_10");
    run(2'b00, 32'd7,          32'hFFFF_FFFE,  5'd31, 32'hFFFF_FFFD,   33,      0, "div_7_m2");
    run(2'b10, 32'd7,          32'hFFFF_FFFE,  5'd31, 32'd1,           33,      0, "rem_7_m2");
    run(2'b00, 32'd0,          32'd5,          5'd2,  32'd0,           LatZero, 0, "div_zero_a");
    run(2'b01, 32'd1000,       32'd10,         5'd12, 32'd100,         33,      10, "divu_poked");
    run(2'b00, 32'd50,         32'd5,          5'd0,  32'd10,          33,      0, "div_rd0");

    // Abort mid-CALC: outputs must drop at once and nothing is written back.
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd99;
    bus.b     = 32'd9;
    bus.rd    = 5'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_we3", {31'd0, bus.we3}, 32'd0);
    chk("abort_wd3", bus.wd3, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run(2'b01, 32'd99, 32'd9, 5'd4, 32'd11, 33, 0, "divu_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
